// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with fetch/execute handshakes, flush and load-use bubbles
package opcodes_pkg;
  localparam int OPCODES_WIDTH = 4;
  typedef enum logic [OPCODES_WIDTH-1:0] {
    NOP_OP, ADD_OP, SUB_OP, AND_OP, OR_OP, MUL_OP, DIV_OP, XOR_OP,
    LW_OP, SW_OP, BEQ_OP, BLT_OP, BLE_OP, JMP_OP
  } opcode_e;
endpackage

package cmp_pkg;
  typedef enum logic [1:0] {CMP_NOP, CMP_BEQ, CMP_BLT, CMP_BLE} cmp_op_e;
endpackage

package alu_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_DIV, ALU_XOR} alu_op_e;
endpackage

module decode_stage
  import opcodes_pkg::*, cmp_pkg::*, alu_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REG = 32,
  parameter int CNT_WIDTH = 16,
  localparam int REG_SELECT = $clog2(NUM_REG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [REG_WIDTH-1:0]  i_instruction,
  input  logic [REG_WIDTH-1:0]  i_pc,
  input  logic                  i_nop,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [REG_WIDTH-1:0]  o_pc,
  output logic [REG_SELECT-1:0] o_select_a,
  output logic [REG_SELECT-1:0] o_select_b,
  output logic [REG_SELECT-1:0] o_select_c,
  output logic                  o_is_write,
  output logic                  o_is_load,
  output logic                  o_is_store,
  output logic                  o_is_cmp,
  output cmp_op_e               o_cmp_op,
  output alu_op_e               o_alu_op,
  output logic [REG_WIDTH-1:0]  o_offset,
  output logic [CNT_WIDTH-1:0]  o_stall_count
);
  localparam int OW = OPCODES_WIDTH;
  localparam int IMM_WIDTH = REG_WIDTH - OW - 2*REG_SELECT;
  if (IMM_WIDTH <= REG_SELECT) begin : g_imm_chk
    $error("decode_stage: IMM_WIDTH must exceed REG_SELECT");
  end
  if (REG_WIDTH != 32 && REG_WIDTH != 64) begin : g_width_chk
    $error("decode_stage: REG_WIDTH must be 32 or 64");
  end
  logic [OW-1:0] op;
  logic [REG_SELECT-1:0] fa, fb, fc, ld_dest;
  logic [IMM_WIDTH-1:0] imm, lw_imm;
  logic [REG_WIDTH-1:0] sx_lw, sx_sw, sx_br, sx_jmp, offset;
  logic is_alu, is_br, is_write, is_cmp, rd_a, rd_b, ld_pending, hazard, accept, bubble;
  cmp_op_e cmp_op;
  alu_op_e alu_op;
  assign op = i_nop ? OW'(NOP_OP) : i_instruction[REG_WIDTH-1 -: OW];
  assign fa = i_instruction[REG_WIDTH-OW-1 -: REG_SELECT];
  assign fb = i_instruction[REG_WIDTH-OW-REG_SELECT-1 -: REG_SELECT];
  assign imm = i_instruction[IMM_WIDTH-1:0];
  assign fc = imm[IMM_WIDTH-1 -: REG_SELECT];
  assign lw_imm = {fb, imm[IMM_WIDTH-REG_SELECT-1:0]};
  assign sx_lw = {{(REG_WIDTH-IMM_WIDTH){lw_imm[IMM_WIDTH-1]}}, lw_imm};
  assign sx_sw = {{(REG_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign sx_br = {{(REG_WIDTH-IMM_WIDTH-2){imm[IMM_WIDTH-1]}}, imm, 2'b00};
  assign sx_jmp = {{(OW-2){i_instruction[REG_WIDTH-OW-1]}}, i_instruction[REG_WIDTH-OW-1:0], 2'b00};
  assign is_alu = op inside {ADD_OP, SUB_OP, AND_OP, OR_OP, MUL_OP, DIV_OP, XOR_OP};
  assign is_br = op inside {BEQ_OP, BLT_OP, BLE_OP};
  assign is_write = is_alu | (op == LW_OP);
  assign is_cmp = is_br | (op == JMP_OP);
  assign rd_a = is_alu | is_br | (op == SW_OP) | (op == LW_OP);
  assign rd_b = is_alu | is_br | (op == SW_OP);
  always_comb begin
    cmp_op = op == BEQ_OP ? CMP_BEQ : op == BLT_OP ? CMP_BLT :
             (op == BLE_OP || op == JMP_OP) ? CMP_BLE : CMP_NOP;
    offset = op == LW_OP ? sx_lw : op == SW_OP ? sx_sw : is_br ? sx_br :
             op == JMP_OP ? sx_jmp : '0;
    case (op)
      ADD_OP: alu_op = ALU_ADD;
      SUB_OP: alu_op = ALU_SUB;
      AND_OP: alu_op = ALU_AND;
      OR_OP:  alu_op = ALU_OR;
      MUL_OP: alu_op = ALU_MUL;
      DIV_OP: alu_op = ALU_DIV;
      XOR_OP: alu_op = ALU_XOR;
      LW_OP, SW_OP, BEQ_OP, BLT_OP, BLE_OP, JMP_OP: alu_op = ALU_ADD;
      default: alu_op = ALU_OR;
    endcase
  end
  assign hazard = i_valid & ld_pending & ((rd_a & (fa == ld_dest)) | (rd_b & (fb == ld_dest)));
  assign o_ready = (!o_valid | i_ready) & !hazard & !i_flush;
  assign accept = i_valid & o_ready;
  assign bubble = hazard & (!o_valid | i_ready) & !i_flush;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_valid <= 1'b0;
      ld_pending <= 1'b0;
      ld_dest <= '0;
      o_stall_count <= '0;
      o_pc <= '0;
      o_select_a <= '0;
      o_select_b <= '0;
      o_select_c <= '0;
      o_is_write <= 1'b0;
      o_is_load <= 1'b0;
      o_is_store <= 1'b0;
      o_is_cmp <= 1'b0;
      o_cmp_op <= CMP_NOP;
      o_alu_op <= ALU_OR;
      o_offset <= '0;
    end else begin
      if (bubble && o_stall_count != '1) o_stall_count <= o_stall_count + 1'b1;
      if (i_flush) begin
        o_valid <= 1'b0;
        ld_pending <= 1'b0;
      end else if (accept) begin
        o_valid <= 1'b1;
        ld_pending <= op == LW_OP;
        if (op == LW_OP) ld_dest <= fc;
        o_pc <= i_pc;
        o_select_a <= fa;
        o_select_b <= fb;
        o_select_c <= fc;
        o_is_write <= is_write;
        o_is_load <= op == LW_OP;
        o_is_store <= op == SW_OP;
        o_is_cmp <= is_cmp;
        o_cmp_op <= cmp_op;
        o_alu_op <= alu_op;
        o_offset <= offset;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        ld_pending <= 1'b0;
      end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, handshakes, hazards, flush and reset
module tb_decode_stage;
  import opcodes_pkg::*, cmp_pkg::*, alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic flush, valid, rdy, nop, ovalid, iready, wr, ld, st, cm;
  logic [31:0] instr, pc, opc, off;
  logic [4:0] sa, sb, sc;
  logic [15:0] cnt;
  cmp_op_e cop;
  alu_op_e aop;
  logic w_flush, w_valid, w_rdy, w_nop, w_ovalid, w_iready, w_wr, w_ld, w_st, w_cm;
  logic [63:0] w_instr, w_pc, w_opc, w_off;
  logic [3:0] w_sa, w_sb, w_sc;
  logic [1:0] w_cnt;
  cmp_op_e w_cop;
  alu_op_e w_aop;
  decode_stage u0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy),
    .i_instruction(instr), .i_pc(pc), .i_nop(nop), .o_valid(ovalid), .i_ready(iready),
    .o_pc(opc), .o_select_a(sa), .o_select_b(sb), .o_select_c(sc), .o_is_write(wr),
    .o_is_load(ld), .o_is_store(st), .o_is_cmp(cm), .o_cmp_op(cop), .o_alu_op(aop),
    .o_offset(off), .o_stall_count(cnt)
  );
  decode_stage #(.REG_WIDTH(64), .NUM_REG(16), .CNT_WIDTH(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_flush(w_flush), .i_valid(w_valid), .o_ready(w_rdy),
    .i_instruction(w_instr), .i_pc(w_pc), .i_nop(w_nop), .o_valid(w_ovalid), .i_ready(w_iready),
    .o_pc(w_opc), .o_select_a(w_sa), .o_select_b(w_sb), .o_select_c(w_sc), .o_is_write(w_wr),
    .o_is_load(w_ld), .o_is_store(w_st), .o_is_cmp(w_cm), .o_cmp_op(w_cop), .o_alu_op(w_aop),
    .o_offset(w_off), .o_stall_count(w_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ins(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b, input logic [17:0] imm);
    return {op, a, b, imm};
  endfunction
  initial begin
    {flush, valid, nop, iready} = '0;
    instr = '0;
    pc = '0;
    {w_flush, w_valid, w_nop, w_iready} = '0;
    w_instr = '0;
    w_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", ovalid, 0);
    chk("rst_alu", aop, ALU_OR);
    chk("rst_cmp", cop, CMP_NOP);
    chk("rst_pc", opc, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", rdy, 1);
    valid = 1; iready = 1; instr = ins(ADD_OP, 1, 2, {5'd3, 13'd0}); pc = 32'h100;
    #1 chk("add_ready", rdy, 1);
    step;
    chk("add_valid", ovalid, 1);
    chk("add_alu", aop, ALU_ADD);
    chk("add_write", wr, 1);
    chk("add_c", sc, 3);
    chk("add_pc", opc, 32'h100);
    chk("add_off", off, 0);
    instr = ins(XOR_OP, 2, 3, {5'd7, 13'd0}); pc = 32'h104;
    #1 chk("xor_ready", rdy, 1);
    step;
    chk("xor_alu", aop, ALU_XOR);
    chk("xor_pc", opc, 32'h104);
    instr = ins(LW_OP, 1, 0, {5'd4, 13'h10}); pc = 32'h108;
    step;
    chk("lw_load", ld, 1);
    chk("lw_off", off, 32'h10);
    chk("lw_c", sc, 4);
    chk("lw_alu", aop, ALU_ADD);
    instr = ins(SUB_OP, 4, 5, 18'd0); pc = 32'h10c;
    #1 chk("haz_ready", rdy, 0);
    step;
    chk("bubble_valid", ovalid, 0);
    chk("bubble_cnt", cnt, 1);
    chk("after_bubble_ready", rdy, 1);
    step;
    chk("sub_alu", aop, ALU_SUB);
    chk("sub_pc", opc, 32'h10c);
    instr = ins(LW_OP, 1, 16, {5'd4, 13'd0}); pc = 32'h110;
    step;
    chk("lw_neg_off", off, 32'hFFFE0000);
    instr = ins(SUB_OP, 6, 7, 18'd0); pc = 32'h114;
    #1 chk("nohaz_ready", rdy, 1);
    step;
    chk("nohaz_pc", opc, 32'h114);
    chk("nohaz_cnt", cnt, 1);
    instr = ins(LW_OP, 1, 0, {5'd4, 13'd0}); pc = 32'h118;
    step;
    instr = {4'(JMP_OP), 28'hFFFFFFF}; pc = 32'h11c;
    #1 chk("jmp_ready", rdy, 1);
    step;
    chk("jmp_off", off, 32'hFFFFFFFC);
    chk("jmp_cmp", cop, CMP_BLE);
    chk("jmp_is_cmp", cm, 1);
    chk("jmp_write", wr, 0);
    chk("jmp_alu", aop, ALU_ADD);
    instr = ins(BLT_OP, 2, 3, 18'd5); pc = 32'h200;
    step;
    chk("blt_pc", opc, 32'h200);
    iready = 0; instr = ins(ADD_OP, 9, 9, 18'd0); pc = 32'h204;
    repeat (3) begin
      #1 chk("hold_ready", rdy, 0);
      step;
      chk("hold_valid", ovalid, 1);
      chk("hold_pc", opc, 32'h200);
      chk("hold_off", off, 32'h14);
      chk("hold_cmp", cop, CMP_BLT);
    end
    iready = 1;
    #1 chk("release_ready", rdy, 1);
    step;
    chk("release_pc", opc, 32'h204);
    chk("release_alu", aop, ALU_ADD);
    instr = ins(LW_OP, 1, 0, {5'd4, 13'd0}); pc = 32'h300;
    step;
    chk("fl_lw", ld, 1);
    flush = 1; instr = ins(SUB_OP, 4, 5, 18'd0); pc = 32'h304;
    #1 chk("flush_ready", rdy, 0);
    step;
    chk("flush_valid", ovalid, 0);
    flush = 0;
    #1 chk("post_flush_ready", rdy, 1);
    step;
    chk("post_flush_pc", opc, 32'h304);
    chk("flush_cnt", cnt, 1);
    instr = {4'hF, 28'h1234567}; pc = 32'h400;
    step;
    chk("unk_alu", aop, ALU_OR);
    chk("unk_cmp", cop, CMP_NOP);
    chk("unk_write", wr, 0);
    chk("unk_off", off, 0);
    chk("unk_pc", opc, 32'h400);
    nop = 1; instr = ins(SW_OP, 1, 2, 18'h3FFFF); pc = 32'h404;
    step;
    chk("nop_alu", aop, ALU_OR);
    chk("nop_store", st, 0);
    chk("nop_off", off, 0);
    chk("nop_pc", opc, 32'h404);
    nop = 0; valid = 0; iready = 0;
    #1 rst = 1;
    #1 chk("async_rst_valid", ovalid, 0);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_pc", opc, 0);
    @(posedge clk);
    #1 rst = 0;
    w_valid = 1; w_iready = 1; w_instr = {4'(SW_OP), 4'd1, 4'd2, 52'h8000000000001}; w_pc = 64'h1000;
    step;
    chk("w_sw_off", w_off, 64'hFFF8000000000001);
    chk("w_sw_store", w_st, 1);
    chk("w_sw_pc", w_opc, 64'h1000);
    for (int i = 0; i < 5; i++) begin
      w_instr = {4'(LW_OP), 4'd1, 4'd0, 4'd2, 48'd0};
      step;
      w_instr = {4'(ADD_OP), 4'd2, 4'd0, 52'd0};
      #1 chk("w_haz_ready", w_rdy, 0);
      step;
      step;
    end
    chk("w_sat_cnt", w_cnt, 3);
    chk("w_add_alu", w_aop, ALU_ADD);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
